hazard_forward_ctrl: RTL and testbench

//  Parametrised pipeline control for the ARM core. Merges RAW hazard detection, N-source operand forwarding,

---
 rtl/hazard_forward_ctrl_pkg.sv | 17 +
 rtl/hazard_forward_ctrl_if.sv | 55 +++++
 rtl/hazard_forward_ctrl_fwd_match_sel.sv | 26 ++
 rtl/hazard_forward_ctrl.sv | 164 ++++++++++++++++
 tb/tb_hazard_forward_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types and helpers for the hazard/forwarding pipeline controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1
  } mem_state_t;

  // Operand-mux select value meaning "take the register file".
  localparam int FWD_RF = 0;

  // Width of an operand-mux select covering the register file plus n forwarding sources.
  function automatic int fwd_sel_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Bundle of pipeline-side signals exchanged with hazard_forward_ctrl.
// master: the pipeline datapath (drives hazard inputs, consumes enables/selects).
// slave : the controller.
interface hazard_forward_ctrl_if
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_FWD    = 2,
  parameter int CNT_W      = 32
);
  localparam int SEL_W = fwd_sel_w(NUM_FWD);

  logic                          forward_en;
  logic [REG_ADDR_W-1:0]         id_src1;
  logic [REG_ADDR_W-1:0]         id_src2;
  logic                          id_use_src1;
  logic                          id_use_src2;
  logic [REG_ADDR_W-1:0]         exe_src1;
  logic [REG_ADDR_W-1:0]         exe_src2;
  logic [REG_ADDR_W-1:0]         exe_dest;
  logic                          exe_wb_en;
  logic                          exe_mem_read;
  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_dest;
  logic [NUM_FWD-1:0]            fwd_wb_en;
  logic                          branch_taken;
  logic                          mem_req;
  logic                          mem_ready;

  logic [SEL_W-1:0]              fwd_sel1;
  logic [SEL_W-1:0]              fwd_sel2;
  logic                          stall_fetch;
  logic                          bubble_exe;
  logic                          freeze_back;
  logic                          flush;
  logic [CNT_W-1:0]              cnt_stall;
  logic [CNT_W-1:0]              cnt_mem;
  logic [CNT_W-1:0]              cnt_flush;

  modport master (
    output forward_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_src1, exe_src2, exe_dest, exe_wb_en, exe_mem_read,
           fwd_dest, fwd_wb_en, branch_taken, mem_req, mem_ready,
    input  fwd_sel1, fwd_sel2, stall_fetch, bubble_exe, freeze_back, flush,
           cnt_stall, cnt_mem, cnt_flush
  );

  modport slave (
    input  forward_en, id_src1, id_src2, id_use_src1, id_use_src2,
           exe_src1, exe_src2, exe_dest, exe_wb_en, exe_mem_read,
           fwd_dest, fwd_wb_en, branch_taken, mem_req, mem_ready,
    output fwd_sel1, fwd_sel2, stall_fetch, bubble_exe, freeze_back, flush,
           cnt_stall, cnt_mem, cnt_flush
  );

endinterface

// File: rtl/hazard_forward_ctrl_fwd_match_sel.sv
// Per-operand forwarding priority encoder: picks the youngest downstream
// producer (lowest index) whose destination matches the operand register.
module fwd_match_sel
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 4,
  parameter int NUM_FWD    = 2,
  parameter int SEL_W      = fwd_sel_w(NUM_FWD)
) (
  input  logic [REG_ADDR_W-1:0]         src,
  input  logic [NUM_FWD*REG_ADDR_W-1:0] fwd_dest,
  input  logic [NUM_FWD-1:0]            fwd_wb_en,
  output logic [SEL_W-1:0]              sel
);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = NUM_FWD - 1; k >= 0; k--) begin
      if (fwd_wb_en[k] && (fwd_dest[k*REG_ADDR_W +: REG_ADDR_W] == src)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Pipeline hazard controller: RAW detection, operand forwarding selects,
// branch flush sequencing and a variable-latency memory wait FSM.
// Optional feature macro: PERF_COUNTERS_EN (saturating stall/mem/flush counters).
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_ADDR_W  = 4,
  parameter int NUM_FWD     = 2,
  parameter int FLUSH_DEPTH = 1,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  hazard_forward_ctrl_if.slave  bus
);

  localparam int       SEL_W      = fwd_sel_w(NUM_FWD);
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_DEPTH - 1);

  mem_state_t       state_q, state_d;
  logic [2:0]       flush_cnt_q, flush_cnt_d;
  logic             flush_pend_q, flush_pend_d;

  logic [SEL_W-1:0] sel1_raw, sel2_raw;
  logic             freeze;
  logic             flush_act;
  logic             load_use_hit;
  logic             raw_hit;
  logic             data_stall;

  function automatic logic src_hit(input logic used,
                                   input logic [REG_ADDR_W-1:0] src,
                                   input logic [REG_ADDR_W-1:0] dest);
    return used && (src == dest);
  endfunction

  fwd_match_sel #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel1 (
    .src       (bus.exe_src1),
    .fwd_dest  (bus.fwd_dest),
    .fwd_wb_en (bus.fwd_wb_en),
    .sel       (sel1_raw)
  );

  fwd_match_sel #(.REG_ADDR_W(REG_ADDR_W), .NUM_FWD(NUM_FWD), .SEL_W(SEL_W)) u_sel2 (
    .src       (bus.exe_src2),
    .fwd_dest  (bus.fwd_dest),
    .fwd_wb_en (bus.fwd_wb_en),
    .sel       (sel2_raw)
  );

  // RAW detection: load-use only when forwarding, any in-flight producer otherwise.
  always_comb begin
    logic exe_hit;
    logic fwd_hit;
    exe_hit = src_hit(bus.id_use_src1, bus.id_src1, bus.exe_dest) ||
              src_hit(bus.id_use_src2, bus.id_src2, bus.exe_dest);
    fwd_hit = 1'b0;
    for (int k = 0; k < NUM_FWD; k++) begin
      if (bus.fwd_wb_en[k] &&
          (src_hit(bus.id_use_src1, bus.id_src1, bus.fwd_dest[k*REG_ADDR_W +: REG_ADDR_W]) ||
           src_hit(bus.id_use_src2, bus.id_src2, bus.fwd_dest[k*REG_ADDR_W +: REG_ADDR_W]))) begin
        fwd_hit = 1'b1;
      end
    end
    load_use_hit = bus.exe_wb_en && bus.exe_mem_read && exe_hit;
    raw_hit      = (bus.exe_wb_en && exe_hit) || fwd_hit;
    data_stall   = bus.forward_en ? load_use_hit : raw_hit;
  end

  // Memory wait FSM and flush sequencing; a frozen pipeline holds the flush count
  // and parks a taken branch until the first unfrozen cycle.
  always_comb begin
    state_d      = state_q;
    flush_cnt_d  = flush_cnt_q;
    flush_pend_d = flush_pend_q;
    freeze       = 1'b0;
    flush_act    = 1'b0;

    case (state_q)
      RUN: begin
        freeze = bus.mem_req && !bus.mem_ready;
        if (freeze) state_d = MEM_WAIT;
      end
      MEM_WAIT: begin
        freeze = !bus.mem_ready;
        if (bus.mem_ready) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    if (freeze) begin
      if (bus.branch_taken) flush_pend_d = 1'b1;
    end else begin
      flush_pend_d = 1'b0;
      if (bus.branch_taken || flush_pend_q) begin
        flush_act   = 1'b1;
        flush_cnt_d = FLUSH_LOAD;
      end else if (flush_cnt_q != 3'd0) begin
        flush_act   = 1'b1;
        flush_cnt_d = flush_cnt_q - 3'd1;
      end
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      flush_cnt_q  <= 3'd0;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_cnt_q  <= flush_cnt_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // Priority freeze > flush > data stall; everything held low during reset.
  assign bus.freeze_back = !rst && freeze;
  assign bus.flush       = !rst && flush_act;
  assign bus.stall_fetch = !rst && (freeze || (!flush_act && data_stall));
  assign bus.bubble_exe  = !rst && !freeze && !flush_act && data_stall;
  assign bus.fwd_sel1    = (!rst && bus.forward_en) ? sel1_raw : SEL_W'(FWD_RF);
  assign bus.fwd_sel2    = (!rst && bus.forward_en) ? sel2_raw : SEL_W'(FWD_RF);

`ifdef PERF_COUNTERS_EN
  logic [CNT_W-1:0] cnt_stall_q, cnt_stall_d;
  logic [CNT_W-1:0] cnt_mem_q,   cnt_mem_d;
  logic [CNT_W-1:0] cnt_flush_q, cnt_flush_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
    return (en && (v != {CNT_W{1'b1}})) ? v + CNT_W'(1) : v;
  endfunction

  // Saturating event counters.
  always_comb begin
    cnt_stall_d = sat_inc(cnt_stall_q, bus.bubble_exe);
    cnt_mem_d   = sat_inc(cnt_mem_q,   bus.freeze_back);
    cnt_flush_d = sat_inc(cnt_flush_q, bus.flush);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_stall_q <= '0;
      cnt_mem_q   <= '0;
      cnt_flush_q <= '0;
    end else begin
      cnt_stall_q <= cnt_stall_d;
      cnt_mem_q   <= cnt_mem_d;
      cnt_flush_q <= cnt_flush_d;
    end
  end

  assign bus.cnt_stall = cnt_stall_q;
  assign bus.cnt_mem   = cnt_mem_q;
  assign bus.cnt_flush = cnt_flush_q;
`else
  assign bus.cnt_stall = {CNT_W{1'b0}};
  assign bus.cnt_mem   = {CNT_W{1'b0}};
  assign bus.cnt_flush = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl (NUM_FWD=2, FLUSH_DEPTH=2, CNT_W=4).
// Control vector layout: {fwd_sel1[1:0], fwd_sel2[1:0], stall_fetch, bubble_exe, freeze_back, flush}.
module tb_hazard_forward_ctrl;
  import hazard_pkg::*;

  localparam logic [7:0] IDLE  = 8'b00_00_0000;
  localparam logic [7:0] STALL = 8'b00_00_1100;
  localparam logic [7:0] FRZ   = 8'b00_00_1010;
  localparam logic [7:0] FLSH  = 8'b00_00_0001;

  typedef struct {
    string      tag;
    logic [7:0] ctl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] m_stall = 4'd0;
  logic [3:0] m_mem   = 4'd0;
  logic [3:0] m_flush = 4'd0;

  always #5 clk = ~clk;

  hazard_forward_ctrl_if #(.REG_ADDR_W(4), .NUM_FWD(2), .CNT_W(4)) bus_if ();

  hazard_forward_ctrl #(.REG_ADDR_W(4), .NUM_FWD(2), .FLUSH_DEPTH(2), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  function automatic logic [7:0] obs_ctl();
    return {bus_if.fwd_sel1, bus_if.fwd_sel2, bus_if.stall_fetch,
            bus_if.bubble_exe, bus_if.freeze_back, bus_if.flush};
  endfunction

  function automatic logic [3:0] sat4(input logic [3:0] v);
    return (v == 4'hF) ? v : v + 4'd1;
  endfunction

  task automatic clr();
    bus_if.forward_en   = 1'b1;
    bus_if.id_src1      = '0;
    bus_if.id_src2      = '0;
    bus_if.id_use_src1  = 1'b0;
    bus_if.id_use_src2  = 1'b0;
    bus_if.exe_src1     = '0;
    bus_if.exe_src2     = '0;
    bus_if.exe_dest     = '0;
    bus_if.exe_wb_en    = 1'b0;
    bus_if.exe_mem_read = 1'b0;
    bus_if.fwd_dest     = '0;
    bus_if.fwd_wb_en    = '0;
    bus_if.branch_taken = 1'b0;
    bus_if.mem_req      = 1'b0;
    bus_if.mem_ready    = 1'b0;
  endtask

  task automatic load_use_hit();
    bus_if.exe_mem_read = 1'b1;
    bus_if.exe_wb_en    = 1'b1;
    bus_if.exe_dest     = 4'd5;
    bus_if.id_src2      = 4'd5;
    bus_if.id_use_src2  = 1'b1;
  endtask

  // One clock cycle: queue expectation, compare at the falling edge, advance.
  task automatic cyc(input string tag, input logic [7:0] exp_ctl);
    exp_t e;
    exp_t got;
    logic [11:0] cnt_obs;
    e.tag = tag;
    e.ctl = exp_ctl;
    sb.push_back(e);
    @(negedge clk);
    got = sb.pop_front();
    checks++;
    assert (obs_ctl() === got.ctl) else begin
      failures++;
      $error("FAIL %s ctl observed=%b expected=%b", got.tag, obs_ctl(), got.ctl);
    end
    cnt_obs = {bus_if.cnt_stall, bus_if.cnt_mem, bus_if.cnt_flush};
    checks++;
    assert (cnt_obs === {m_stall, m_mem, m_flush}) else begin
      failures++;
      $error("FAIL %s_cnt observed=%h expected=%h", got.tag, cnt_obs, {m_stall, m_mem, m_flush});
    end
    if (rst) begin
      m_stall = 4'd0;
      m_mem   = 4'd0;
      m_flush = 4'd0;
    end else begin
`ifdef PERF_COUNTERS_EN
      if (got.ctl[2]) m_stall = sat4(m_stall);
      if (got.ctl[1]) m_mem   = sat4(m_mem);
      if (got.ctl[0]) m_flush = sat4(m_flush);
`endif
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_state(input string tag, input mem_state_t exp_st);
    checks++;
    assert (dut.state_q === exp_st) else begin
      failures++;
      $error("FAIL %s state observed=%0d expected=%0d", tag, dut.state_q, exp_st);
    end
  endtask

  initial begin
    clr();
    // Hostile inputs while in reset: every output must still read 0.
    bus_if.mem_req      = 1'b1;
    bus_if.branch_taken = 1'b1;
    bus_if.fwd_dest     = 8'h33;
    bus_if.fwd_wb_en    = 2'b11;
    bus_if.exe_src1     = 4'd3;
    load_use_hit();
    @(posedge clk);
    #1;
    cyc("reset_outputs_zero", IDLE);
    chk_state("reset_state", RUN);
    rst = 1'b0;
    clr();
    cyc("idle", IDLE);

    // Forwarding selects
    bus_if.fwd_dest = 8'h33; bus_if.fwd_wb_en = 2'b11;
    bus_if.exe_src1 = 4'd3;  bus_if.exe_src2 = 4'd3;
    cyc("fwd_youngest_wins", 8'b01_01_0000);
    bus_if.fwd_wb_en = 2'b10;
    cyc("fwd_oldest_only", 8'b10_10_0000);
    bus_if.fwd_wb_en = 2'b00;
    cyc("fwd_no_wb", IDLE);
    bus_if.fwd_dest = {4'd7, 4'd3}; bus_if.fwd_wb_en = 2'b11; bus_if.exe_src2 = 4'd7;
    cyc("fwd_split", 8'b01_10_0000);
    bus_if.exe_src1 = 4'd9;
    cyc("fwd_nomatch", 8'b00_10_0000);
    bus_if.forward_en = 1'b0;
    cyc("fwd_disabled", IDLE);
    clr();

    // Data hazards
    load_use_hit();
    cyc("load_use", STALL);
    clr();
    cyc("load_use_one_cycle", IDLE);
    load_use_hit(); bus_if.id_use_src2 = 1'b0;
    cyc("load_use_src_unused", IDLE);
    bus_if.id_use_src2 = 1'b1; bus_if.exe_mem_read = 1'b0;
    cyc("alu_raw_forwarded", IDLE);
    clr();
    bus_if.forward_en = 1'b0; bus_if.fwd_dest = {4'd5, 4'd0}; bus_if.fwd_wb_en = 2'b10;
    bus_if.id_src2 = 4'd5; bus_if.id_use_src2 = 1'b1;
    cyc("nofwd_raw_fwd1", STALL);
    bus_if.fwd_wb_en = 2'b00; bus_if.exe_wb_en = 1'b1; bus_if.exe_dest = 4'd5;
    cyc("nofwd_raw_exe", STALL);
    clr();
    bus_if.forward_en = 1'b0; bus_if.fwd_dest = 8'h02; bus_if.fwd_wb_en = 2'b01;
    bus_if.id_src1 = 4'd2; bus_if.id_use_src1 = 1'b1;
    cyc("nofwd_raw_fwd0_src1", STALL);
    clr();

    // Memory wait: freeze overrides a concurrent load-use stall
    bus_if.mem_req = 1'b1; load_use_hit();
    cyc("mem_freeze_1", FRZ);
    chk_state("mem_enter_wait", MEM_WAIT);
    cyc("mem_freeze_2", FRZ);
    cyc("mem_freeze_3", FRZ);
    chk_state("mem_still_wait", MEM_WAIT);
    clr(); bus_if.mem_ready = 1'b1;
    cyc("mem_release", IDLE);
    chk_state("mem_back_run", RUN);
    bus_if.mem_req = 1'b1;
    cyc("mem_zero_wait", IDLE);
    chk_state("mem_zero_wait_run", RUN);
    clr();

    // Flush overrides a load-use stall, lasts two cycles
    bus_if.branch_taken = 1'b1; load_use_hit();
    cyc("flush_c1_over_stall", FLSH);
    bus_if.branch_taken = 1'b0;
    cyc("flush_c2", FLSH);
    cyc("flush_done_stall", STALL);
    clr();
    cyc("flush_idle", IDLE);
    bus_if.branch_taken = 1'b1;
    cyc("reload_c1", FLSH);
    cyc("reload_c2", FLSH);
    bus_if.branch_taken = 1'b0;
    cyc("reload_c3", FLSH);
    cyc("reload_end", IDLE);

    // Branch while frozen: flush deferred to first unfrozen cycle
    bus_if.mem_req = 1'b1; bus_if.branch_taken = 1'b1;
    cyc("pend_frozen_branch", FRZ);
    bus_if.branch_taken = 1'b0;
    cyc("pend_frozen", FRZ);
    bus_if.mem_req = 1'b0; bus_if.mem_ready = 1'b1;
    cyc("pend_flush_c1", FLSH);
    bus_if.mem_ready = 1'b0;
    cyc("pend_flush_c2", FLSH);
    cyc("pend_end", IDLE);

    // Long wait drives cnt_mem into saturation
    bus_if.mem_req = 1'b1;
    for (int i = 0; i < 16; i++) cyc($sformatf("sat_freeze_%0d", i), FRZ);
    clr(); bus_if.mem_ready = 1'b1;
    cyc("sat_release", IDLE);
    clr();
    cyc("sat_hold", IDLE);

    // Reset in the middle of a memory wait
    bus_if.mem_req = 1'b1;
    cyc("pre_rst_freeze", FRZ);
    chk_state("pre_rst_wait", MEM_WAIT);
    rst = 1'b1;
    cyc("rst_in_wait", IDLE);
    chk_state("rst_abandons_wait", RUN);
    rst = 1'b0; bus_if.mem_req = 1'b0;
    cyc("after_rst_idle", IDLE);
    cyc("after_rst_idle2", IDLE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
